// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a registered carry, LSB first.
// Define OVERFLOW_DET_EN to add the registered signed-overflow output ovf.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef OVERFLOW_DET_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CountLast = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_sum_shift;
    logic [CW-1:0]    r_count;
    logic             r_carry;
    logic             r_cout;
    logic             w_load;
    logic             w_shift;
    logic             w_last;
    logic             w_s;
    logic             w_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = StShift;
                end
            end
            StShift: begin
                w_shift = 1'b1;
                if (r_count == CountLast) begin
                    w_last       = 1'b1;
                    w_state_next = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // The single full-adder cell shared by every bit position.
    assign w_s = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_c = (r_a_sr[0] & r_b_sr[0]) | (r_carry & (r_a_sr[0] ^ r_b_sr[0]));

    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_shift = w_s;
        end else begin : g_sum_wn
            assign w_sum_shift = {w_s, r_sum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_sum   <= '0;
            r_count <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_load) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_count <= '0;
        end else if (w_shift) begin
            r_a_sr  <= r_a_sr >> 1;
            r_b_sr  <= r_b_sr >> 1;
            r_sum   <= w_sum_shift;
            r_carry <= w_c;
            r_count <= r_count + CW'(1);
            if (w_last) begin
                r_cout <= w_c;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

`ifdef OVERFLOW_DET_EN
    logic r_ovf;

    // On the last cycle r_carry is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_c;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
